// File: rtl/h_logic_accum.sv
// h_logic_accum: bursts of words folded by OR/AND/XOR/LAST into one held result
module h_logic_accum #(
  parameter int WIDTH = 16,
  parameter int MAX_BEATS = 8,
  localparam int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_trunc
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  logic [1:0] state;
  logic [1:0] op_r;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic take, first, term;
  assign in_ready = state != HOLD;
  assign out_valid = state == HOLD;
  assign out_data = acc;
  assign out_count = cnt;
  assign take = in_valid && in_ready;
  assign first = state == IDLE;
  // next accumulator/count for an accepted beat; the op is latched from the first beat only
  always_comb begin
    cnt_nx = first ? CW'(1) : cnt + CW'(1);
    acc_nx = first          ? in_data :
             op_r == 2'b00  ? acc | in_data :
             op_r == 2'b01  ? acc & in_data :
             op_r == 2'b10  ? acc ^ in_data : in_data;
    term = in_last || cnt_nx == CW'(MAX_BEATS);
  end
  // burst FSM: accumulate until in_last or MAX_BEATS, then hold until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      op_r <= 2'b00;
      out_trunc <= 1'b0;
    end else if (take) begin
      acc <= acc_nx;
      cnt <= cnt_nx;
      if (first) op_r <= in_op;
      state <= term ? HOLD : ACCUM;
      if (term) out_trunc <= !in_last;
    end else if (out_valid && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_h_logic_accum.sv
// tb_h_logic_accum: directed bursts checked by a queue-based burst model and literal expectations
module tb_h_logic_accum;
  localparam int W = 16;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic [1:0] in_op = 2'b00;
  logic in_ready, out_valid, out_trunc;
  logic [W-1:0] out_data;
  logic [CW-1:0] out_count;
  int errors = 0, checks = 0;
  bit pend = 0;
  logic [W-1:0] words[$];
  logic [1:0] mop = 0;
  logic [W-1:0] exp_data = 0;
  int exp_cnt = 0;
  bit exp_trunc = 0;

  h_logic_accum #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fold(input logic [W-1:0] w[$], input logic [1:0] op);
    logic [W-1:0] r = w[0];
    for (int i = 1; i < w.size(); i++)
      case (op)
        2'b00: r = r | w[i];
        2'b01: r = r & w[i];
        2'b10: r = r ^ w[i];
        default: r = w[i];
      endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend = 0;
      words = {};
      exp_data = 0;
      exp_cnt = 0;
      exp_trunc = 0;
    end else if (pend) begin
      if (out_ready) pend = 0;
    end else if (in_valid) begin
      if (words.size() == 0) mop = in_op;
      words.push_back(in_data);
      if (in_last || words.size() == MB) begin
        exp_data = fold(words, mop);
        exp_cnt = words.size();
        exp_trunc = !in_last;
        pend = 1;
        words = {};
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_in_ready", in_ready, !pend);
      chk("m_out_valid", out_valid, pend);
      if (pend) begin
        chk("m_out_data", out_data, exp_data);
        chk("m_out_count", out_count, exp_cnt);
        chk("m_out_trunc", out_trunc, exp_trunc);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [1:0] op, input logic last);
    in_valid = 1;
    in_data = d;
    in_op = op;
    in_last = last;
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic pop();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic res(input string n, input logic [W-1:0] d, input int c, input bit t);
    chk({n, "_valid"}, out_valid, 1);
    chk({n, "_data"}, out_data, d);
    chk({n, "_count"}, out_count, c);
    chk({n, "_trunc"}, out_trunc, t);
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    send(16'h0001, 2'b00, 0);
    send(16'h0010, 2'b11, 0);
    send(16'h0100, 2'b01, 1);
    res("or3", 16'h0111, 3, 0);
    pop();
    send(16'hFFFF, 2'b01, 0);
    send(16'h0F0F, 2'b10, 1);
    res("and2", 16'h0F0F, 2, 0);
    pop();
    send(16'h00FF, 2'b10, 0);
    send(16'h0F0F, 2'b10, 0);
    send(16'h3333, 2'b10, 0);
    send(16'h5555, 2'b10, 0);
    res("xor_trunc", 16'h6996, 4, 1);
    chk("xor_trunc_ready", in_ready, 0);
    repeat (3) begin
      @(negedge clk);
      res("hold", 16'h6996, 4, 1);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1;
    in_valid = 1;
    in_data = 16'hDEAD;
    in_op = 2'b00;
    in_last = 1;
    @(negedge clk);
    out_ready = 0;
    chk("drain_valid", out_valid, 0);
    chk("drain_ready", in_ready, 1);
    chk("drain_keep", out_data, 16'h6996);
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
    res("bubble", 16'hDEAD, 1, 0);
    pop();
    send(16'hF0F1, 2'b01, 0);
    send(16'hFF03, 2'b00, 0);
    send(16'h0FFF, 2'b00, 0);
    send(16'h00F5, 2'b00, 1);
    res("and4_last", 16'h0001, 4, 0);
    pop();
    send(16'h1000, 2'b00, 0);
    repeat (5) @(negedge clk);
    chk("gap_ready", in_ready, 1);
    send(16'h0002, 2'b01, 0);
    repeat (3) @(negedge clk);
    send(16'h0040, 2'b10, 1);
    res("gap_or", 16'h1042, 3, 0);
    pop();
    send(16'h0003, 2'b00, 0);
    send(16'h0300, 2'b00, 0);
    #2 rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_count", out_count, 0);
    chk("arst_trunc", out_trunc, 0);
    chk("arst_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    send(16'hAAAA, 2'b11, 1);
    res("last1", 16'hAAAA, 1, 0);
    pop();
    for (int op = 0; op < 4; op++) begin
      send(16'h1234, 2'(op), 1);
      res("single", 16'h1234, 1, 0);
      pop();
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
